// File: rtl/instruction_sequencer_pkg.sv
// Shared types and defaults for the instruction sequencer and its field decoder.
// Operand type codes match the 2-bit encoding carried in the instruction word.
package instruction_sequencer_pkg;

  localparam int DEF_INSTRUCTION_WIDTH = 64;
  localparam int DEF_OPCODE_WIDTH      = 6;
  localparam int DEF_DATA_WIDTH        = 16;
  localparam int DEF_PC_WIDTH          = 8;
  localparam logic [5:0] DEF_HALT_OPCODE = 6'h3F;

  localparam int FIELD_ADDR_WIDTH = 8;
  localparam int FIELD_REG_WIDTH  = 3;

  typedef enum logic [1:0] {
    OP_REG  = 2'b00,
    OP_MEM  = 2'b01,
    OP_IMM  = 2'b10,
    OP_NONE = 2'b11
  } operand_type_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_READ1  = 3'd3,
    ST_READ2  = 3'd4,
    ST_EXEC   = 3'd5,
    ST_WRITE  = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  function automatic logic is_mem(input operand_type_e t);
    return (t == OP_MEM);
  endfunction

endpackage

// File: rtl/instruction_sequencer_parser.sv
// Field decoder: splits the instruction register into opcode, operand types,
// 8-bit address fields and 3-bit register fields, packed upward from bit 0.
module instruction_sequencer_parser
  import instruction_sequencer_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
  parameter int OPCODE_WIDTH      = DEF_OPCODE_WIDTH
) (
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [OPCODE_WIDTH-1:0]      opcode,
  output operand_type_e                address1_type,
  output operand_type_e                address2_type,
  output operand_type_e                out_type,
  output logic [FIELD_ADDR_WIDTH-1:0]  address1,
  output logic [FIELD_ADDR_WIDTH-1:0]  address2,
  output logic [FIELD_ADDR_WIDTH-1:0]  address_out,
  output logic [FIELD_REG_WIDTH-1:0]   register1,
  output logic [FIELD_REG_WIDTH-1:0]   register2,
  output logic [FIELD_REG_WIDTH-1:0]   register_out
);

  localparam int T1_LSB     = OPCODE_WIDTH;
  localparam int T2_LSB     = T1_LSB + 2;
  localparam int TO_LSB     = T2_LSB + 2;
  localparam int A1_LSB     = TO_LSB + 2;
  localparam int A2_LSB     = A1_LSB + FIELD_ADDR_WIDTH;
  localparam int AO_LSB     = A2_LSB + FIELD_ADDR_WIDTH;
  localparam int R1_LSB     = AO_LSB + FIELD_ADDR_WIDTH;
  localparam int R2_LSB     = R1_LSB + FIELD_REG_WIDTH;
  localparam int RO_LSB     = R2_LSB + FIELD_REG_WIDTH;
  localparam int FIELDS_MSB = RO_LSB + FIELD_REG_WIDTH - 1;

  logic unused_high_bits;

  assign opcode        = instruction[OPCODE_WIDTH-1:0];
  assign address1_type = operand_type_e'(instruction[T1_LSB +: 2]);
  assign address2_type = operand_type_e'(instruction[T2_LSB +: 2]);
  assign out_type      = operand_type_e'(instruction[TO_LSB +: 2]);
  assign address1      = instruction[A1_LSB +: FIELD_ADDR_WIDTH];
  assign address2      = instruction[A2_LSB +: FIELD_ADDR_WIDTH];
  assign address_out   = instruction[AO_LSB +: FIELD_ADDR_WIDTH];
  assign register1     = instruction[R1_LSB +: FIELD_REG_WIDTH];
  assign register2     = instruction[R2_LSB +: FIELD_REG_WIDTH];
  assign register_out  = instruction[RO_LSB +: FIELD_REG_WIDTH];

  assign unused_high_bits = ^instruction[INSTRUCTION_WIDTH-1:FIELDS_MSB+1];

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle fetch/decode/operand/execute/writeback controller; sole master of
// the data memory port. All requests and strobes are driven straight from flops.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
  parameter int OPCODE_WIDTH      = DEF_OPCODE_WIDTH,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int PC_WIDTH          = DEF_PC_WIDTH,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = DEF_HALT_OPCODE
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         run,
  output logic                         imem_req,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic                         imem_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_data,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [2:0]                   reg_raddr1,
  output logic [2:0]                   reg_raddr2,
  input  logic [DATA_WIDTH-1:0]        reg_rdata1,
  input  logic [DATA_WIDTH-1:0]        reg_rdata2,
  output logic                         reg_we,
  output logic [2:0]                   reg_waddr,
  output logic [DATA_WIDTH-1:0]        reg_wdata,
  output logic                         dmem_rd,
  output logic                         dmem_wr,
  output logic [7:0]                   dmem_addr,
  output logic [DATA_WIDTH-1:0]        dmem_wdata,
  input  logic                         dmem_ready,
  input  logic [DATA_WIDTH-1:0]        dmem_rdata,
  output logic [DATA_WIDTH-1:0]        operand1,
  output logic [DATA_WIDTH-1:0]        operand2,
  output logic                         alu_start,
  input  logic                         alu_done,
  input  logic [DATA_WIDTH-1:0]        alu_result,
  output logic [PC_WIDTH-1:0]          pc,
  output logic                         halted,
  output logic                         busy
);

  state_e                       state_q, state_d;
  logic [PC_WIDTH-1:0]          pc_q, pc_d;
  logic [INSTRUCTION_WIDTH-1:0] instruction_q, instruction_d;
  logic [DATA_WIDTH-1:0]        operand1_q, operand1_d;
  logic [DATA_WIDTH-1:0]        operand2_q, operand2_d;
  logic [DATA_WIDTH-1:0]        result_q, result_d;
  logic                         imem_req_q, imem_req_d;
  logic [PC_WIDTH-1:0]          imem_addr_q, imem_addr_d;
  logic                         reg_we_q, reg_we_d;
  logic [2:0]                   reg_waddr_q, reg_waddr_d;
  logic                         dmem_rd_q, dmem_rd_d;
  logic                         dmem_wr_q, dmem_wr_d;
  logic [7:0]                   dmem_addr_q, dmem_addr_d;
  logic                         alu_start_q, alu_start_d;
  logic                         halted_q, halted_d;
  logic                         busy_q, busy_d;

  logic                         read1_done_s, read2_done_s, write_done_s;

  logic [OPCODE_WIDTH-1:0]      opcode_s;
  operand_type_e                addr1_type_s, addr2_type_s, out_type_s;
  logic [7:0]                   address1_s, address2_s, address_out_s;
  logic [2:0]                   register1_s, register2_s, register_out_s;

  instruction_sequencer_parser #(
    .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
    .OPCODE_WIDTH      (OPCODE_WIDTH)
  ) u_parser (
    .instruction   (instruction_q),
    .opcode        (opcode_s),
    .address1_type (addr1_type_s),
    .address2_type (addr2_type_s),
    .out_type      (out_type_s),
    .address1      (address1_s),
    .address2      (address2_s),
    .address_out   (address_out_s),
    .register1     (register1_s),
    .register2     (register2_s),
    .register_out  (register_out_s)
  );

  // Next-state and next-output computation; requests are raised on the
  // transition into the state that owns them so the first cycle can complete.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instruction_d = instruction_q;
    operand1_d    = operand1_q;
    operand2_d    = operand2_q;
    result_d      = result_q;
    imem_req_d    = imem_req_q;
    imem_addr_d   = imem_addr_q;
    reg_we_d      = 1'b0;
    reg_waddr_d   = reg_waddr_q;
    dmem_rd_d     = dmem_rd_q;
    dmem_wr_d     = dmem_wr_q;
    dmem_addr_d   = dmem_addr_q;
    alu_start_d   = 1'b0;
    halted_d      = halted_q;
    read1_done_s  = 1'b0;
    read2_done_s  = 1'b0;
    write_done_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d     = ST_FETCH;
          imem_req_d  = 1'b1;
          imem_addr_d = pc_q;
        end
      end
      ST_FETCH: begin
        if (imem_valid) begin
          instruction_d = imem_data;
          imem_req_d    = 1'b0;
          state_d       = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (opcode_s == HALT_OPCODE) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = ST_READ1;
          if (is_mem(addr1_type_s)) begin
            dmem_rd_d   = 1'b1;
            dmem_addr_d = address1_s;
          end
        end
      end
      ST_READ1: begin
        case (addr1_type_s)
          OP_REG: begin
            operand1_d   = reg_rdata1;
            read1_done_s = 1'b1;
          end
          OP_MEM: begin
            if (dmem_ready) begin
              operand1_d   = dmem_rdata;
              read1_done_s = 1'b1;
            end
          end
          OP_IMM: begin
            operand1_d   = DATA_WIDTH'(address1_s);
            read1_done_s = 1'b1;
          end
          default: begin
            operand1_d   = '0;
            read1_done_s = 1'b1;
          end
        endcase
      end
      ST_READ2: begin
        case (addr2_type_s)
          OP_REG: begin
            operand2_d   = reg_rdata2;
            read2_done_s = 1'b1;
          end
          OP_MEM: begin
            if (dmem_ready) begin
              operand2_d   = dmem_rdata;
              read2_done_s = 1'b1;
            end
          end
          OP_IMM: begin
            operand2_d   = DATA_WIDTH'(address2_s);
            read2_done_s = 1'b1;
          end
          default: begin
            operand2_d   = '0;
            read2_done_s = 1'b1;
          end
        endcase
      end
      ST_EXEC: begin
        // alu_done coinciding with the start pulse belongs to no request yet.
        if (!alu_start_q && alu_done) begin
          result_d = alu_result;
          state_d  = ST_WRITE;
          case (out_type_s)
            OP_REG: begin
              reg_we_d    = 1'b1;
              reg_waddr_d = register_out_s;
            end
            OP_MEM: begin
              dmem_wr_d   = 1'b1;
              dmem_addr_d = address_out_s;
            end
            default: begin
            end
          endcase
        end
      end
      ST_WRITE: begin
        if (!is_mem(out_type_s) || dmem_ready) begin
          write_done_s = 1'b1;
        end
      end
      ST_HALT: begin
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (read1_done_s) begin
      state_d   = ST_READ2;
      dmem_rd_d = is_mem(addr2_type_s);
      if (is_mem(addr2_type_s)) begin
        dmem_addr_d = address2_s;
      end
    end
    if (read2_done_s) begin
      state_d     = ST_EXEC;
      dmem_rd_d   = 1'b0;
      alu_start_d = 1'b1;
    end
    if (write_done_s) begin
      dmem_wr_d   = 1'b0;
      pc_d        = pc_q + PC_WIDTH'(1'b1);
      state_d     = ST_FETCH;
      imem_req_d  = 1'b1;
      imem_addr_d = pc_q + PC_WIDTH'(1'b1);
    end

    busy_d = (state_d != ST_IDLE) && (state_d != ST_HALT);
  end

  // State, datapath registers and registered request outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      instruction_q <= '0;
      operand1_q    <= '0;
      operand2_q    <= '0;
      result_q      <= '0;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      reg_we_q      <= 1'b0;
      reg_waddr_q   <= 3'd0;
      dmem_rd_q     <= 1'b0;
      dmem_wr_q     <= 1'b0;
      dmem_addr_q   <= 8'd0;
      alu_start_q   <= 1'b0;
      halted_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instruction_q <= instruction_d;
      operand1_q    <= operand1_d;
      operand2_q    <= operand2_d;
      result_q      <= result_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      reg_we_q      <= reg_we_d;
      reg_waddr_q   <= reg_waddr_d;
      dmem_rd_q     <= dmem_rd_d;
      dmem_wr_q     <= dmem_wr_d;
      dmem_addr_q   <= dmem_addr_d;
      alu_start_q   <= alu_start_d;
      halted_q      <= halted_d;
      busy_q        <= busy_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instruction = instruction_q;
  assign reg_raddr1  = register1_s;
  assign reg_raddr2  = register2_s;
  assign reg_we      = reg_we_q;
  assign reg_waddr   = reg_waddr_q;
  assign reg_wdata   = result_q;
  assign dmem_rd     = dmem_rd_q;
  assign dmem_wr     = dmem_wr_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_wdata  = result_q;
  assign operand1    = operand1_q;
  assign operand2    = operand2_q;
  assign alu_start   = alu_start_q;
  assign pc          = pc_q;
  assign halted      = halted_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench: directed programs push expected fetch/execute/write events;
// a negedge monitor pops and compares each event the sequencer presents.
module tb_instruction_sequencer;

  localparam int EV_FETCH = 0;
  localparam int EV_EXEC  = 1;
  localparam int EV_REGW  = 2;
  localparam int EV_MEMW  = 3;
  localparam int EV_MEMR  = 4;

  localparam logic [1:0] T_REG = 2'b00, T_MEM = 2'b01, T_IMM = 2'b10, T_NONE = 2'b11;

  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] d2;
    int          lat;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        imem_req, imem_valid;
  logic [7:0]  imem_addr;
  logic [63:0] imem_data, instruction;
  logic [2:0]  reg_raddr1, reg_raddr2, reg_waddr;
  logic [15:0] reg_rdata1, reg_rdata2, reg_wdata;
  logic        reg_we, dmem_rd, dmem_wr, dmem_ready;
  logic [7:0]  dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata, operand1, operand2, alu_result;
  logic        alu_start, alu_done, halted, busy;
  logic [7:0]  pc;

  logic [63:0] imem_mem [256];
  logic [15:0] dmem_mem [256];
  logic [15:0] regs [8];
  int          dmem_wait = 0;
  int          dcnt = 0;
  logic        ready_force = 1'b0;
  logic        alu_done_always = 1'b0;
  logic        alu_start_d1 = 1'b0;

  ev_t         exp_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;

  instruction_sequencer dut (
    .clock(clock), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .instruction(instruction),
    .reg_raddr1(reg_raddr1), .reg_raddr2(reg_raddr2),
    .reg_rdata1(reg_rdata1), .reg_rdata2(reg_rdata2),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .dmem_rd(dmem_rd), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .operand1(operand1), .operand2(operand2),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .pc(pc), .halted(halted), .busy(busy)
  );

  always #5 clock = ~clock;

  // Environment models: zero-wait imem, register file, wait-programmable dmem, adder ALU.
  assign imem_valid = imem_req;
  assign imem_data  = imem_mem[imem_addr];
  assign reg_rdata1 = regs[reg_raddr1];
  assign reg_rdata2 = regs[reg_raddr2];
  assign dmem_ready = ((dmem_rd || dmem_wr) && (dcnt == dmem_wait)) || ready_force;
  assign dmem_rdata = dmem_mem[dmem_addr];
  assign alu_done   = alu_done_always || alu_start_d1;
  assign alu_result = operand1 + operand2;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    alu_start_d1 <= alu_start;
    if (!(dmem_rd || dmem_wr) || dmem_ready) dcnt <= 0;
    else dcnt <= dcnt + 1;
  end

  function automatic logic [63:0] mk(input logic [5:0] op, input logic [1:0] t1, input logic [1:0] t2,
                                     input logic [1:0] to, input logic [7:0] a1, input logic [7:0] a2,
                                     input logic [7:0] ao, input logic [2:0] r1, input logic [2:0] r2,
                                     input logic [2:0] ro);
    logic [63:0] w;
    w = 64'd0;
    w[5:0] = op; w[7:6] = t1; w[9:8] = t2; w[11:10] = to;
    w[19:12] = a1; w[27:20] = a2; w[35:28] = ao;
    w[38:36] = r1; w[41:39] = r2; w[44:42] = ro;
    return w;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input int kind, input logic [15:0] a, input logic [15:0] d,
                      input logic [15:0] d2, input int lat);
    ev_t e;
    e.kind = kind; e.a = a; e.d = d; e.d2 = d2; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_empty(input int max, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  // Monitor state
  logic        imem_req_prev = 1'b0;
  logic        pend_prev = 1'b0;
  logic        unstable = 1'b0;
  logic [7:0]  pend_addr;
  logic [15:0] pend_wdata;
  logic        pend_rd;
  int          last_fetch = 0;
  int          ev_idx = 0;
  int          ev_kind;
  logic [15:0] ev_a, ev_d, ev_d2;
  logic        ev_hit;
  ev_t         e_m;

  // Monitor: detect one output event per cycle and compare it with the scoreboard head.
  always @(negedge clock) begin
    if (reset) begin
      imem_req_prev = 1'b0;
      pend_prev = 1'b0;
      unstable = 1'b0;
    end else begin
      if (dmem_rd || dmem_wr) begin
        if (pend_prev && (dmem_addr != pend_addr || dmem_wdata != pend_wdata || dmem_rd != pend_rd))
          unstable = 1'b1;
        pend_addr = dmem_addr; pend_wdata = dmem_wdata; pend_rd = dmem_rd;
        pend_prev = !dmem_ready;
      end else begin
        pend_prev = 1'b0;
      end

      ev_hit = 1'b1; ev_a = 16'd0; ev_d = 16'd0; ev_d2 = 16'd0; ev_kind = -1;
      if (imem_req && !imem_req_prev) begin ev_kind = EV_FETCH; ev_a = {8'd0, imem_addr}; end
      else if (alu_start) begin ev_kind = EV_EXEC; ev_d = operand1; ev_d2 = operand2; end
      else if (reg_we) begin ev_kind = EV_REGW; ev_a = {13'd0, reg_waddr}; ev_d = reg_wdata; end
      else if (dmem_wr && dmem_ready) begin ev_kind = EV_MEMW; ev_a = {8'd0, dmem_addr}; ev_d = dmem_wdata; end
      else if (dmem_rd && dmem_ready) begin ev_kind = EV_MEMR; ev_a = {8'd0, dmem_addr}; end
      else ev_hit = 1'b0;

      if (ev_hit) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_event_kind%0d", ev_kind), ev_kind, -1);
        end else begin
          e_m = exp_q.pop_front();
          check($sformatf("ev%0d_kind", ev_idx), ev_kind, e_m.kind);
          if (e_m.kind != EV_EXEC) check($sformatf("ev%0d_addr", ev_idx), ev_a, e_m.a);
          if (e_m.kind == EV_EXEC || e_m.kind == EV_REGW || e_m.kind == EV_MEMW)
            check($sformatf("ev%0d_data", ev_idx), ev_d, e_m.d);
          if (e_m.kind == EV_EXEC) check($sformatf("ev%0d_operand2", ev_idx), ev_d2, e_m.d2);
          if (e_m.kind == EV_MEMW || e_m.kind == EV_MEMR) begin
            check($sformatf("ev%0d_dmem_hold", ev_idx), unstable, 0);
            check($sformatf("ev%0d_rd_wr_excl", ev_idx), dmem_rd && dmem_wr, 0);
            unstable = 1'b0;
          end
          if (ev_kind == EV_FETCH && e_m.lat != 0)
            check($sformatf("ev%0d_fetch_latency", ev_idx), cyc - last_fetch, e_m.lat);
        end
        if (ev_kind == EV_FETCH) last_fetch = cyc;
        ev_idx++;
      end
      imem_req_prev = imem_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] halt_word;
    int n;
    halt_word = mk(6'h3F, T_NONE, T_NONE, T_NONE, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0);
    for (int i = 0; i < 256; i++) begin imem_mem[i] = halt_word; dmem_mem[i] = 16'h0000; end
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    regs[1] = 16'd5; regs[2] = 16'd7;
    dmem_mem[8'h20] = 16'h0011;

    // Phase 1: reset state, then a short directed program ending in HALT.
    repeat (2) tick();
    check("rst_pc", pc, 0);
    check("rst_instruction", instruction, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_rd", dmem_rd, 0);
    check("rst_dmem_wr", dmem_wr, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_alu_start", alu_start, 0);
    check("rst_operands", {operand1, operand2}, 0);
    reset = 1'b0;

    imem_mem[0] = mk(6'h01, T_REG, T_REG, T_REG, 8'h00, 8'h00, 8'h00, 3'd1, 3'd2, 3'd3);
    imem_mem[1] = mk(6'h01, T_MEM, T_IMM, T_MEM, 8'h20, 8'h05, 8'h40, 3'd0, 3'd0, 3'd0);
    imem_mem[2] = mk(6'h02, T_NONE, T_REG, T_NONE, 8'h00, 8'h00, 8'h00, 3'd0, 3'd2, 3'd0);
    imem_mem[3] = mk(6'h01, T_IMM, T_NONE, T_REG, 8'hAB, 8'h00, 8'h00, 3'd0, 3'd0, 3'd5);
    imem_mem[4] = halt_word;
    dmem_wait = 3;
    alu_done_always = 1'b1;

    push(EV_FETCH, 16'd0, 16'd0, 16'd0, 0);
    push(EV_EXEC, 16'd0, 16'd5, 16'd7, 0);
    push(EV_REGW, 16'd3, 16'd12, 16'd0, 0);
    push(EV_FETCH, 16'd1, 16'd0, 16'd0, 7);
    push(EV_MEMR, 16'h20, 16'd0, 16'd0, 0);
    push(EV_EXEC, 16'd0, 16'h0011, 16'h0005, 0);
    push(EV_MEMW, 16'h40, 16'h0016, 16'd0, 0);
    push(EV_FETCH, 16'd2, 16'd0, 16'd0, 13);
    push(EV_EXEC, 16'd0, 16'd0, 16'd7, 0);
    push(EV_FETCH, 16'd3, 16'd0, 16'd0, 7);
    push(EV_EXEC, 16'd0, 16'h00AB, 16'd0, 0);
    push(EV_REGW, 16'd5, 16'h00AB, 16'd0, 0);
    push(EV_FETCH, 16'd4, 16'd0, 16'd0, 7);

    run = 1'b1; tick(); run = 1'b0;
    wait_empty(200, "prog_events_done");
    repeat (3) tick();
    check("halt_halted", halted, 1);
    check("halt_busy", busy, 0);
    check("halt_pc", pc, 4);
    check("halt_instruction", instruction, halt_word);
    run = 1'b1;
    repeat (6) tick();
    run = 1'b0;
    check("halt_no_fetch", imem_req, 0);
    check("halt_sticky", halted, 1);

    // Phase 2: 256 no-op instructions so pc wraps from 255 to 0.
    reset = 1'b1; tick(); reset = 1'b0;
    alu_done_always = 1'b0;
    dmem_wait = 0;
    for (int i = 0; i < 256; i++)
      imem_mem[i] = mk(6'h04, T_NONE, T_NONE, T_NONE, 8'h00, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0);
    push(EV_FETCH, 16'd0, 16'd0, 16'd0, 0);
    push(EV_EXEC, 16'd0, 16'd0, 16'd0, 0);
    for (int i = 1; i < 256; i++) begin
      push(EV_FETCH, 16'(i), 16'd0, 16'd0, 7);
      push(EV_EXEC, 16'd0, 16'd0, 16'd0, 0);
    end
    push(EV_FETCH, 16'd0, 16'd0, 16'd0, 7);
    run = 1'b1; tick(); run = 1'b0;
    repeat (20) tick();
    imem_mem[0] = halt_word;
    wait_empty(3000, "wrap_events_done");
    repeat (3) tick();
    check("wrap_halted", halted, 1);
    check("wrap_pc", pc, 0);

    // Phase 3: reset in the middle of a pending data-memory read.
    reset = 1'b1; tick(); reset = 1'b0;
    imem_mem[0] = mk(6'h01, T_MEM, T_NONE, T_NONE, 8'h30, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0);
    dmem_mem[8'h30] = 16'hBEEF;
    dmem_wait = 8;
    push(EV_FETCH, 16'd0, 16'd0, 16'd0, 0);
    run = 1'b1; tick(); run = 1'b0;
    n = 0;
    while (!dmem_rd && n < 50) begin tick(); n++; end
    check("midrd_dmem_rd_seen", dmem_rd, 1);
    repeat (2) tick();
    #2;
    reset = 1'b1;
    #1;
    check("midrd_rst_dmem_rd", dmem_rd, 0);
    check("midrd_rst_busy", busy, 0);
    check("midrd_rst_pc", pc, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    ready_force = 1'b1;
    tick();
    ready_force = 1'b0;
    tick();
    check("late_ready_busy", busy, 0);
    check("late_ready_dmem_rd", dmem_rd, 0);
    check("late_ready_operand1", operand1, 0);
    check("late_ready_imem_req", imem_req, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
